// File: rtl/backoff_scheduler.sv
// backoff_scheduler: slotted random-backoff scheduler granting one shared transmit path round-robin
module backoff_scheduler #(
    parameter int NREQ        = 4,
    parameter int SLOT_CYCLES = 50
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [23:0]     rand_in,
    input  logic            rand_valid,
    output logic            rand_ack,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] tx_done,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            slot_tick,
    output logic [NREQ-1:0] backoff_active
);
    localparam int CW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [2:0] {IDLE, WAIT_RAND, BACKOFF, READY, GRANTED} state_t;
    state_t          st  [NREQ];
    logic [2:0]      cnt [NREQ];
    logic [CW-1:0]   slot_cnt;
    logic [PW-1:0]   ptr, win;
    logic [NREQ-1:0] waiting, eligible, grant_nxt;
    logic            fire;
    logic            unused_rand;
    assign unused_rand = ^rand_in;
    always_comb begin
        waiting        = '0;
        eligible       = '0;
        backoff_active = '0;
        for (int i = 0; i < NREQ; i++) begin
            waiting[i]        = st[i] == WAIT_RAND;
            eligible[i]       = st[i] == READY && req[i];
            backoff_active[i] = st[i] == WAIT_RAND || st[i] == BACKOFF;
        end
    end
    assign rand_ack = rand_valid && |(waiting & req);
    // first eligible index above ptr wins; otherwise wrap to the lowest one at or below ptr
    always_comb begin
        logic hi_found, lo_found;
        int   hi, lo;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi       = 0;
        lo       = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                if (j > int'(ptr)) begin
                    hi       = j;
                    hi_found = 1'b1;
                end else begin
                    lo       = j;
                    lo_found = 1'b1;
                end
            end
        end
        win       = PW'(hi_found ? hi : lo);
        fire      = ~|grant && (hi_found || lo_found);
        grant_nxt = (grant & req & ~tx_done) | (fire ? NREQ'(1) << win : '0);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_cnt  <= '0;
            slot_tick <= 1'b0;
            ptr       <= PW'(NREQ - 1);
            grant     <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            slot_tick <= slot_cnt == CW'(SLOT_CYCLES - 1);
            slot_cnt  <= slot_cnt == CW'(SLOT_CYCLES - 1) ? '0 : slot_cnt + 1'b1;
            grant     <= grant_nxt;
            busy      <= |grant_nxt;
            if (fire) ptr <= win;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    st[i]  <= IDLE;
                    cnt[i] <= '0;
                end else begin
                    case (st[i])
                        IDLE:      st[i] <= WAIT_RAND;
                        WAIT_RAND: if (rand_valid) begin
                            st[i]  <= rand_in[3*i +: 3] == 3'd0 ? READY : BACKOFF;
                            cnt[i] <= rand_in[3*i +: 3];
                        end
                        BACKOFF:   if (slot_tick) begin
                            cnt[i] <= cnt[i] - 1'b1;
                            if (cnt[i] == 3'd1) st[i] <= READY;
                        end
                        READY:     if (fire && win == PW'(i)) st[i] <= GRANTED;
                        GRANTED:   if (tx_done[i]) st[i] <= IDLE;
                        default:   st[i] <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_backoff_scheduler.sv
// tb_backoff_scheduler: directed stimulus checked every cycle against a phase-level behavioural model
module tb_backoff_scheduler;
    localparam int N = 4, S = 50;
    localparam int IDLE = 0, WAIT = 1, BO = 2, RDY = 3, GNT = 4;
    logic          clock = 1'b0, reset = 1'b0;
    logic [23:0]   rand_in = '0;
    logic          rand_valid = 1'b0, rand_ack;
    logic [N-1:0]  req = '0, tx_done = '0, grant, backoff_active;
    logic          busy, slot_tick;
    int            tests = 0, fails = 0;
    int            ph [N], rem [N];
    int            m_ptr, m_cyc, win, idx;
    bit            tick;
    logic [N-1:0]  eg, eb;
    logic          ea;

    always #5 clock = ~clock;

    backoff_scheduler #(.NREQ(N), .SLOT_CYCLES(S)) dut (
        .clock(clock), .reset(reset), .rand_in(rand_in), .rand_valid(rand_valid),
        .rand_ack(rand_ack), .req(req), .tx_done(tx_done), .grant(grant), .busy(busy),
        .slot_tick(slot_tick), .backoff_active(backoff_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            ph[i]  = IDLE;
            rem[i] = 0;
        end
        m_ptr = N - 1;
        m_cyc = 0;
    endfunction

    always @(negedge reset) m_reset();

    // model advances on each edge from the inputs held since the last falling edge, then compares
    always @(posedge clock) begin
        if (!reset) m_reset();
        else begin
            tick = m_cyc > 0 && m_cyc % S == 0;
            win  = -1;
            eg   = '0;
            for (int i = 0; i < N; i++) eg[i] = ph[i] == GNT;
            if (eg == '0)
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && ph[idx] == RDY && req[idx]) win = idx;
                end
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    ph[i]  = IDLE;
                    rem[i] = 0;
                end else if (ph[i] == IDLE) ph[i] = WAIT;
                else if (ph[i] == WAIT && rand_valid) begin
                    rem[i] = int'((rand_in >> (3 * i)) & 24'h7);
                    ph[i]  = rem[i] == 0 ? RDY : BO;
                end else if (ph[i] == BO && tick) begin
                    rem[i]--;
                    if (rem[i] == 0) ph[i] = RDY;
                end else if (ph[i] == RDY && win == i) ph[i] = GNT;
                else if (ph[i] == GNT && tx_done[i]) ph[i] = IDLE;
            end
            if (win >= 0) m_ptr = win;
            m_cyc++;
        end
        #1;
        eg = '0;
        eb = '0;
        ea = 1'b0;
        for (int i = 0; i < N; i++) begin
            eg[i] = ph[i] == GNT;
            eb[i] = ph[i] == WAIT || ph[i] == BO;
            if (ph[i] == WAIT && req[i] && rand_valid) ea = 1'b1;
        end
        chk("model_grant", grant, eg);
        chk("model_busy", busy, |eg);
        chk("model_slot_tick", slot_tick, m_cyc > 0 && m_cyc % S == 0);
        chk("model_backoff_active", backoff_active, eb);
        chk("model_rand_ack", rand_ack, ea);
    end

    task automatic goto(input int c);
        while (m_cyc < c) @(negedge clock);
    endtask

    task automatic load_rand(input logic [23:0] v);
        rand_in    = v;
        rand_valid = 1'b1;
        @(negedge clock);
        rand_valid = 1'b0;
    endtask

    // waits (bounded) for a grant, checks it, then releases it with tx_done on every index
    task automatic serve(input string name, input logic [N-1:0] exp);
        int n = 0;
        while (grant == '0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(name, grant, exp);
        chk({name, "_busy"}, busy, 1);
        tx_done = '1;
        @(negedge clock);
        tx_done = '0;
        chk({name, "_release"}, grant, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clock);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_slot_tick", slot_tick, 0);
        reset = 1'b1;
        goto(49);  chk("tick_49", slot_tick, 0);
        goto(50);  chk("tick_50", slot_tick, 1);
        goto(51);  chk("tick_51", slot_tick, 0);
        goto(100); chk("tick_100", slot_tick, 1);
        goto(150); chk("tick_150", slot_tick, 1);
        chk("idle_grant", grant, 0);
        req = 4'b0001;
        @(negedge clock);
        rand_in    = 24'h000003;
        rand_valid = 1'b1;
        #1 chk("t2_rand_ack", rand_ack, 1);
        @(negedge clock);
        rand_valid = 1'b0;
        goto(300); chk("t2_backoff_300", backoff_active, 4'b0001);
        goto(301); chk("t2_backoff_301", backoff_active, 0);
        chk("t2_grant_301", grant, 0);
        goto(302); chk("t2_grant_302", grant, 4'b0001);
        chk("t2_busy_302", busy, 1);
        tx_done = 4'b0001;
        @(negedge clock);
        tx_done = '0;
        req     = '0;
        chk("t2_release", grant, 0);
        req = 4'b0011;
        @(negedge clock);
        load_rand(24'h000005);
        repeat (2) @(negedge clock);
        chk("t6_grant_before", grant, 4'b0010);
        chk("t6_backoff_before", backoff_active, 4'b0001);
        reset = 1'b0;
        #1;
        chk("t6_abort_grant", grant, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_backoff", backoff_active, 0);
        chk("t6_abort_tick", slot_tick, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        chk("t6_no_grant", grant, 0);
        chk("t6_waiting", backoff_active, 4'b0011);
        load_rand(24'h000000);
        @(negedge clock);
        chk("t6_ptr_reset", grant, 4'b0001);
        req = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        req = 4'b1111;
        @(negedge clock);
        rand_in    = '0;
        rand_valid = 1'b1;
        #1 chk("t3_rand_ack", rand_ack, 1);
        @(negedge clock);
        rand_valid = 1'b0;
        serve("t3_g0", 4'b0001);
        serve("t3_g1", 4'b0010);
        serve("t3_g2", 4'b0100);
        serve("t3_g3", 4'b1000);
        req = '0;
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        load_rand(24'h000000);
        @(negedge clock);
        chk("t4_g2", grant, 4'b0100);
        req = 4'b1101;
        @(negedge clock);
        load_rand(24'h000000);
        serve("t4_g2_serve", 4'b0100);
        serve("t4_g3", 4'b1000);
        serve("t4_g0", 4'b0001);
        req = '0;
        @(negedge clock);
        req = 4'b0010;
        @(negedge clock);
        load_rand(24'h000000);
        @(negedge clock);
        chk("t5_grant1", grant, 4'b0010);
        req = '0;
        @(negedge clock);
        chk("t5_drop_grant", grant, 0);
        chk("t5_drop_busy", busy, 0);
        req = 4'b0100;
        @(negedge clock);
        load_rand(24'h0001C0);
        chk("t5_backoff2", backoff_active, 4'b0100);
        req = '0;
        @(negedge clock);
        chk("t5_drop_backoff", backoff_active, 0);
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
